// File: rtl/host_device_bus_pkg.sv
// Shared helpers for the host/device bus: index-width sizing used by the
// arbiter and the top-level response registers.
package host_device_bus_pkg;

  // Width of an index into n ports; a single port still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/host_device_bus_prio_arb.sv
// Fixed-priority arbiter: the lowest-index requester wins, reported as a
// one-hot grant, a binary index and a valid flag.
module bus_prio_arb
  import host_device_bus_pkg::*;
#(
  parameter int N    = 1,
  parameter int IdxW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic found;

  always_comb begin
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/host_device_bus.sv
// Single-cycle-response interconnect: arbitrates hosts, decodes the target
// device by mask/base and routes the device response back one cycle later.
module host_device_bus
  import host_device_bus_pkg::*;
#(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      host_req_i           [NrHosts],
  output logic                      host_gnt_o           [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i          [NrHosts],
  input  logic                      host_we_i            [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i            [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i         [NrHosts],
  output logic                      host_rvalid_o        [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o         [NrHosts],
  output logic                      host_err_o           [NrHosts],
  output logic                      device_req_o         [NrDevices],
  output logic [AddressWidth-1:0]   device_addr_o        [NrDevices],
  output logic                      device_we_o          [NrDevices],
  output logic [DataWidth/8-1:0]    device_be_o          [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o       [NrDevices],
  input  logic                      device_rvalid_i      [NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i       [NrDevices],
  input  logic                      device_err_i         [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

  localparam int HostIdxW = idx_width(NrHosts);
  localparam int DevIdxW  = idx_width(NrDevices);
  localparam int BeW      = DataWidth / 8;

  logic [NrHosts-1:0]      req_vec;
  logic [NrHosts-1:0]      gnt_vec;
  logic [HostIdxW-1:0]     win_idx;
  logic                    win_valid;

  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [BeW-1:0]          win_be;
  logic [DataWidth-1:0]    win_wdata;

  logic                    dev_hit;
  logic [DevIdxW-1:0]      dev_idx;

  logic                    resp_pending_q, resp_pending_d;
  logic [HostIdxW-1:0]     resp_host_q, resp_host_d;
  logic [DevIdxW-1:0]      resp_dev_q, resp_dev_d;
  logic                    resp_unmapped_q, resp_unmapped_d;

  logic                    resp_rvalid;
  logic [DataWidth-1:0]    resp_rdata;
  logic                    resp_err;

  for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host_req
    assign req_vec[gi]    = host_req_i[gi];
    assign host_gnt_o[gi] = gnt_vec[gi];
  end

  bus_prio_arb #(
    .N    (NrHosts),
    .IdxW (HostIdxW)
  ) u_arb (
    .req_i   (req_vec),
    .gnt_o   (gnt_vec),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // One-hot grant selects the winner's fields; all zero when nobody requests.
  always_comb begin
    win_addr  = '0;
    win_we    = 1'b0;
    win_be    = '0;
    win_wdata = '0;
    for (int h = 0; h < NrHosts; h++) begin
      if (gnt_vec[h]) begin
        win_addr  = host_addr_i[h];
        win_we    = host_we_i[h];
        win_be    = host_be_i[h];
        win_wdata = host_wdata_i[h];
      end
    end
  end

  always_comb begin
    dev_hit = 1'b0;
    dev_idx = '0;
    for (int d = 0; d < NrDevices; d++) begin
      if (!dev_hit && ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
        dev_hit = 1'b1;
        dev_idx = DevIdxW'(d);
      end
    end
  end

  for (genvar gi = 0; gi < NrDevices; gi++) begin : g_dev_out
    assign device_req_o[gi]   = win_valid && dev_hit && (dev_idx == DevIdxW'(gi));
    assign device_addr_o[gi]  = win_addr;
    assign device_we_o[gi]    = win_we;
    assign device_be_o[gi]    = win_be;
    assign device_wdata_o[gi] = win_wdata;
  end

  always_comb begin
    resp_pending_d  = win_valid;
    resp_host_d     = resp_host_q;
    resp_dev_d      = resp_dev_q;
    resp_unmapped_d = resp_unmapped_q;
    if (win_valid) begin
      resp_host_d     = win_idx;
      resp_dev_d      = dev_idx;
      resp_unmapped_d = !dev_hit;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_pending_q  <= 1'b0;
      resp_host_q     <= '0;
      resp_dev_q      <= '0;
      resp_unmapped_q <= 1'b0;
    end else begin
      resp_pending_q  <= resp_pending_d;
      resp_host_q     <= resp_host_d;
      resp_dev_q      <= resp_dev_d;
      resp_unmapped_q <= resp_unmapped_d;
    end
  end

  // Gating by pending keeps a device answer to a reset-discarded access off the hosts.
  always_comb begin
    resp_rvalid = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    if (resp_pending_q) begin
      if (resp_unmapped_q) begin
        resp_rvalid = 1'b1;
        resp_err    = 1'b1;
      end else begin
        for (int d = 0; d < NrDevices; d++) begin
          if (resp_dev_q == DevIdxW'(d)) begin
            resp_rvalid = device_rvalid_i[d];
            resp_rdata  = device_rdata_i[d];
            resp_err    = device_err_i[d];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host_resp
    logic sel;
    assign sel                = (resp_host_q == HostIdxW'(gi));
    assign host_rvalid_o[gi]  = sel ? resp_rvalid : 1'b0;
    assign host_rdata_o[gi]   = sel ? resp_rdata : '0;
    assign host_err_o[gi]     = sel ? resp_err : 1'b0;
  end

endmodule

// File: tb/tb_host_device_bus.sv
// Directed bench for host_device_bus with 2 hosts and 3 devices; a reference
// model pushes expected responses to a queue at grant time and pops them a cycle later.
module tb_host_device_bus;

  localparam int NH = 2;
  localparam int ND = 3;

  typedef struct {
    int          due;
    int          host;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req    [NH];
  logic        host_gnt    [NH];
  logic [31:0] host_addr   [NH];
  logic        host_we     [NH];
  logic [3:0]  host_be     [NH];
  logic [31:0] host_wdata  [NH];
  logic        host_rvalid [NH];
  logic [31:0] host_rdata  [NH];
  logic        host_err    [NH];
  logic        dev_req     [ND];
  logic [31:0] dev_addr    [ND];
  logic        dev_we      [ND];
  logic [3:0]  dev_be      [ND];
  logic [31:0] dev_wdata   [ND];
  logic        dev_rvalid  [ND];
  logic [31:0] dev_rdata   [ND];
  logic        dev_err_o   [ND];
  logic [31:0] cfg_base    [ND];
  logic [31:0] cfg_mask    [ND];

  logic [31:0] dev_data    [ND];
  logic        dev_err     [ND];

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  host_device_bus #(
    .NrDevices    (ND),
    .NrHosts      (NH),
    .DataWidth    (32),
    .AddressWidth (32)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .host_req_i           (host_req),
    .host_gnt_o           (host_gnt),
    .host_addr_i          (host_addr),
    .host_we_i            (host_we),
    .host_be_i            (host_be),
    .host_wdata_i         (host_wdata),
    .host_rvalid_o        (host_rvalid),
    .host_rdata_o         (host_rdata),
    .host_err_o           (host_err),
    .device_req_o         (dev_req),
    .device_addr_o        (dev_addr),
    .device_we_o          (dev_we),
    .device_be_o          (dev_be),
    .device_wdata_o       (dev_wdata),
    .device_rvalid_i      (dev_rvalid),
    .device_rdata_i       (dev_rdata),
    .device_err_i         (dev_err_o),
    .cfg_device_addr_base (cfg_base),
    .cfg_device_addr_mask (cfg_mask)
  );

  always #5 clk = ~clk;

  // Device models answer exactly one cycle after their request.
  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      dev_rvalid[d] <= dev_req[d];
      dev_rdata[d]  <= dev_req[d] ? dev_data[d] : 32'h0;
      dev_err_o[d]  <= dev_req[d] ? dev_err[d] : 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_host(input int h, input logic req, input logic [31:0] addr,
                          input logic we, input logic [3:0] be, input logic [31:0] wdata);
    host_req[h]   = req;
    host_addr[h]  = addr;
    host_we[h]    = we;
    host_be[h]    = be;
    host_wdata[h] = wdata;
  endtask

  task automatic idle_hosts();
    for (int h = 0; h < NH; h++) set_host(h, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  // One bus cycle: check comb request path and the due response, then advance.
  task automatic tick();
    int   win;
    int   dev;
    bit   have;
    bit   hit;
    exp_t e;
    @(negedge clk);
    if (rst) q.delete();
    win = -1;
    for (int h = 0; h < NH; h++) if (host_req[h] && win < 0) win = h;
    dev = -1;
    if (win >= 0)
      for (int d = 0; d < ND; d++)
        if (dev < 0 && ((host_addr[win] & cfg_mask[d]) == cfg_base[d])) dev = d;

    for (int h = 0; h < NH; h++)
      chk($sformatf("c%0d gnt[%0d]", cyc, h), 32'(host_gnt[h]), 32'(h == win));
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("c%0d dev_req[%0d]", cyc, d), 32'(dev_req[d]), 32'(win >= 0 && dev == d));
      chk($sformatf("c%0d dev_addr[%0d]", cyc, d), dev_addr[d], (win >= 0) ? host_addr[win] : 32'h0);
      chk($sformatf("c%0d dev_we[%0d]", cyc, d), 32'(dev_we[d]), (win >= 0) ? 32'(host_we[win]) : 32'h0);
      chk($sformatf("c%0d dev_be[%0d]", cyc, d), 32'(dev_be[d]), (win >= 0) ? 32'(host_be[win]) : 32'h0);
      chk($sformatf("c%0d dev_wdata[%0d]", cyc, d), dev_wdata[d], (win >= 0) ? host_wdata[win] : 32'h0);
    end

    have = (q.size() > 0) && (q[0].due == cyc);
    if (have) e = q.pop_front();
    for (int h = 0; h < NH; h++) begin
      hit = have && (e.host == h);
      chk($sformatf("c%0d rvalid[%0d]", cyc, h), 32'(host_rvalid[h]), 32'(hit));
      chk($sformatf("c%0d rdata[%0d]", cyc, h), host_rdata[h], hit ? e.rdata : 32'h0);
      chk($sformatf("c%0d err[%0d]", cyc, h), 32'(host_err[h]), hit ? 32'(e.err) : 32'h0);
    end

    $display("cycle %0d: rst=%0b winner=%0d device=%0d response=%0s", cyc, rst, win, dev,
             have ? $sformatf("host%0d data=%h err=%0b", e.host, e.rdata, e.err) : "none");

    if (win >= 0 && !rst) begin
      e.due   = cyc + 1;
      e.host  = win;
      e.rdata = (dev < 0) ? 32'h0 : dev_data[dev];
      e.err   = (dev < 0) ? 1'b1 : dev_err[dev];
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    idle_hosts();
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
    dev_data[0] = 32'hDEAD_BEEF; dev_err[0] = 1'b0;
    dev_data[1] = 32'h0000_1234; dev_err[1] = 1'b0;
    dev_data[2] = 32'hCAFE_F00D; dev_err[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held with a live request: grant path works, no response escapes.
    set_host(0, 1'b1, 32'h0010_0004, 1'b0, 4'hF, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Mapped read of device 0.
    tick();
    idle_hosts();
    tick();

    // Byte write to device 1.
    set_host(0, 1'b1, 32'h0002_0000, 1'b1, 4'b0001, 32'h0000_0041);
    tick();
    idle_hosts();
    tick();

    // Unmapped read.
    set_host(0, 1'b1, 32'h0004_0000, 1'b0, 4'hF, 32'h0);
    tick();
    idle_hosts();
    tick();

    // Two hosts contend; host1 holds its request until granted.
    set_host(0, 1'b1, 32'h0010_0008, 1'b0, 4'hF, 32'h0);
    set_host(1, 1'b1, 32'h0003_0004, 1'b1, 4'b1100, 32'hA5A5_0000);
    tick();
    set_host(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    tick();
    idle_hosts();
    tick();

    // Back-to-back reads to device 0 then device 2, the latter flagging an error.
    dev_err[2]  = 1'b1;
    dev_data[2] = 32'h0BAD_0BAD;
    set_host(0, 1'b1, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
    tick();
    set_host(0, 1'b1, 32'h0003_0010, 1'b0, 4'hF, 32'h0);
    tick();
    idle_hosts();
    tick();

    // Reset arriving while a response is pending discards it.
    set_host(1, 1'b1, 32'h0010_0010, 1'b0, 4'hF, 32'h0);
    tick();
    idle_hosts();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Unmapped access followed immediately by a mapped one from the other host.
    set_host(1, 1'b1, 32'h00FF_0000, 1'b0, 4'hF, 32'h0);
    tick();
    set_host(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_host(0, 1'b1, 32'h0002_03FC, 1'b0, 4'hF, 32'h0);
    tick();
    idle_hosts();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
